disparity_out_packer: RTL and testbench



---
 rtl/disparity_out_packer.sv | 100 ++++++++++
 tb/tb_disparity_out_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/disparity_out_packer.sv
// rtl/disparity_out_packer.sv - packs framed disparity pixels into fixed-width output words
// Frames start on pix_sof; the last word of a frame is zero-padded when the frame ends mid-word.
module disparity_out_packer #(
  parameter int pix_width    = 8,
  parameter int pix_per_word = 2,
  parameter int frame_pixels = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              pix_valid,
  input  logic                              pix_sof,
  input  logic [pix_width-1:0]              pix_data,
  output logic                              out_valid,
  output logic [pix_width*pix_per_word-1:0] out_data,
  output logic                              frame_done,
  output logic                              sync_err,
  output logic [15:0]                       word_count
);

  localparam int word_w = pix_width * pix_per_word;
  localparam int cnt_w  = $clog2(frame_pixels + 1);
  localparam int slot_w = (pix_per_word > 1) ? $clog2(pix_per_word) : 1;
  localparam logic [cnt_w-1:0]  last_cnt  = cnt_w'(frame_pixels);
  localparam logic [slot_w-1:0] last_slot = slot_w'(pix_per_word - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [cnt_w-1:0]    pix_cnt, pix_cnt_nxt;
  logic [slot_w-1:0]   slot_cnt, slot_cnt_nxt;
  logic [word_w-1:0]   shift_reg, shift_reg_nxt;
  logic [word_w-1:0]   out_data_nxt;
  logic                out_valid_nxt, frame_done_nxt, sync_err_nxt;
  logic                start, take;
  logic [slot_w-1:0]   cur_slot;
  logic [cnt_w-1:0]    cur_cnt;
  logic [word_w-1:0]   cur_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      slot_cnt   <= '0;
      shift_reg  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      slot_cnt   <= slot_cnt_nxt;
      shift_reg  <= shift_reg_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      frame_done <= frame_done_nxt;
      sync_err   <= sync_err_nxt;
      if (out_valid_nxt) word_count <= word_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    pix_cnt_nxt    = pix_cnt;
    slot_cnt_nxt   = slot_cnt;
    shift_reg_nxt  = shift_reg;
    out_data_nxt   = out_data;
    out_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;

    // An SOF pixel always opens a fresh word and frame, discarding any partial word.
    start        = pix_valid && pix_sof;
    take         = start || (pix_valid && (state == RUN));
    sync_err_nxt = start && (state == RUN);
    cur_slot     = start ? '0 : slot_cnt;
    cur_cnt      = start ? cnt_w'(1) : pix_cnt + cnt_w'(1);
    cur_word     = start ? '0 : shift_reg;
    cur_word[int'(cur_slot)*pix_width +: pix_width] = pix_data;

    if (take) begin
      state_nxt     = RUN;
      pix_cnt_nxt   = cur_cnt;
      slot_cnt_nxt  = cur_slot + slot_w'(1);
      shift_reg_nxt = cur_word;
      if ((cur_slot == last_slot) || (cur_cnt == last_cnt)) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = cur_word;
        slot_cnt_nxt  = '0;
        shift_reg_nxt = '0;
      end
      if (cur_cnt == last_cnt) begin
        frame_done_nxt = 1'b1;
        state_nxt      = IDLE;
        pix_cnt_nxt    = '0;
      end
    end
  end

endmodule

// File: tb/tb_disparity_out_packer.sv
// tb/tb_disparity_out_packer.sv - scoreboard bench for disparity_out_packer
// Two instances (64- and 5-pixel frames) share one randomized stimulus stream.
module tb_disparity_out_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        ov0, fd0, se0, ov1, fd1, se1;
  logic [15:0] od0, od1, wc0, wc1;

  always #5 clk = ~clk;

  disparity_out_packer dut0 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .out_valid(ov0), .out_data(od0), .frame_done(fd0),
    .sync_err(se0), .word_count(wc0)
  );

  disparity_out_packer #(.frame_pixels(5)) dut1 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .out_valid(ov1), .out_data(od1), .frame_done(fd1),
    .sync_err(se1), .word_count(wc1)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected word entry: {cycle[63:32], 15'b0, frame_done[16], data[15:0]}
  logic [63:0] eq0[$], eq1[$];
  int          sq0[$], sq1[$];
  logic [7:0]  fr0[$], fr1[$];
  bit          in0 = 0, in1 = 0;
  int          ewc0 = 0, ewc1 = 0, nfd0 = 0, nfd1 = 0;
  logic [15:0] last0 = 16'h0, last1 = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: keep the whole current frame as a pixel list; a word is the latest
  // pix_per_word-sized chunk once it is full or the frame reaches its length.
  task automatic model_pix(input int inst, input bit sof, input logic [7:0] d);
    logic [7:0]  fr[$];
    bit          inf;
    int          fpix, n, base;
    logic [15:0] w;
    if (inst == 0) begin fr = fr0; inf = in0; fpix = 64; end
    else begin fr = fr1; inf = in1; fpix = 5; end
    if (sof) begin
      if (inf) begin
        if (inst == 0) sq0.push_back(cyc + 1); else sq1.push_back(cyc + 1);
      end
      fr.delete();
      fr.push_back(d);
      inf = 1;
    end else if (inf) begin
      fr.push_back(d);
    end
    if (inf) begin
      n = fr.size();
      if ((n % 2 == 0) || (n == fpix)) begin
        base = ((n - 1) / 2) * 2;
        w = 16'h0;
        for (int k = base; k < n; k++) w[(k-base)*8 +: 8] = fr[k];
        if (inst == 0) eq0.push_back({32'(cyc + 1), 15'd0, (n == fpix), w});
        else           eq1.push_back({32'(cyc + 1), 15'd0, (n == fpix), w});
      end
      if (n == fpix) inf = 0;
    end
    if (inst == 0) begin fr0 = fr; in0 = inf; end
    else begin fr1 = fr; in1 = inf; end
  endtask

  task automatic mon(input int inst, input logic ov, input logic [15:0] od, input logic fd,
                     input logic se, input logic [15:0] wc);
    logic [63:0] e;
    int          s;
    bit          have;
    if (ov) begin
      have = (inst == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
      if (!have) begin
        checks++; errors++;
        $display("FAIL unexpected_word%0d: got %h expected none", inst, od);
      end else begin
        if (inst == 0) e = eq0.pop_front(); else e = eq1.pop_front();
        check($sformatf("word_data%0d", inst), {16'h0, od}, {16'h0, e[15:0]});
        check($sformatf("word_cycle%0d", inst), cyc, e[63:32]);
        check($sformatf("frame_done%0d", inst), {31'h0, fd}, {31'h0, e[16]});
      end
      if (inst == 0) begin ewc0++; check("word_count0", {16'h0, wc}, 32'(ewc0 & 16'hFFFF)); last0 = od; if (fd) nfd0++; end
      else begin ewc1++; check("word_count1", {16'h0, wc}, 32'(ewc1 & 16'hFFFF)); last1 = od; if (fd) nfd1++; end
    end else if (fd) begin
      checks++; errors++;
      $display("FAIL lone_frame_done%0d: got 1 expected 0", inst);
    end
    if (se) begin
      have = (inst == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
      if (!have) begin
        checks++; errors++;
        $display("FAIL unexpected_sync_err%0d: got 1 expected 0", inst);
      end else begin
        if (inst == 0) s = sq0.pop_front(); else s = sq1.pop_front();
        check($sformatf("sync_err_cycle%0d", inst), cyc, s);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, ov0, od0, fd0, se0, wc0);
      mon(1, ov1, od1, fd1, se1, wc1);
    end
  end

  task automatic send(input bit v, input bit sof, input logic [7:0] d);
    @(negedge clk);
    pix_valid = v;
    pix_sof   = sof;
    pix_data  = d;
    if (v) begin
      model_pix(0, sof, d);
      model_pix(1, sof, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 8'($urandom));
  endtask

  task automatic frame_seq(input int duty);
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(99) >= duty) send(0, 0, 8'($urandom));
      send(1, i == 0, 8'(i));
    end
  endtask

  task automatic flush();
    eq0.delete(); eq1.delete(); sq0.delete(); sq1.delete();
    fr0.delete(); fr1.delete();
    in0 = 0; in1 = 0; ewc0 = 0; ewc1 = 0;
  endtask

  int fd_base;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'h0, ov0}, 32'h0);
    check("reset_out_data", {16'h0, od0}, 32'h0);
    check("reset_frame_done", {31'h0, fd0}, 32'h0);
    check("reset_sync_err", {31'h0, se0}, 32'h0);
    check("reset_word_count", {16'h0, wc0}, 32'h0);
    reset_n = 1'b1;

    frame_seq(100);
    idle(2);
    check("s1_word_count", {16'h0, wc0}, 32'd32);
    check("s1_last_word", {16'h0, last0}, 32'h3F3E);
    check("s1_frames", nfd0, 1);

    send(1, 1, 8'hA1); send(1, 0, 8'hA2); send(1, 0, 8'hA3);
    send(1, 0, 8'hA4); send(1, 0, 8'hA5);
    idle(2);
    check("odd_last_word", {16'h0, last1}, 32'h00A5);

    send(1, 0, 8'h11); send(1, 0, 8'h22);
    send(1, 1, 8'h30); send(1, 0, 8'h31); send(1, 0, 8'h32);
    send(1, 0, 8'h33); send(1, 0, 8'h34);
    idle(2);
    check("nosof_last_word", {16'h0, last1}, 32'h0034);

    send(1, 1, 8'h01); send(1, 0, 8'h02); send(1, 0, 8'h03);
    send(1, 1, 8'h10); send(1, 0, 8'h20);
    idle(2);
    check("restart_last_word", {16'h0, last0}, 32'h2010);

    fd_base = nfd0;
    for (int f = 0; f < 3; f++) frame_seq(50);
    idle(2);
    check("gap_frames", nfd0 - fd_base, 3);
    check("gap_last_word", {16'h0, last0}, 32'h3F3E);

    send(1, 1, 8'h00); send(1, 0, 8'h01);
    @(posedge clk);
    #2;
    check("pre_reset_valid", {31'h0, ov0}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_out_valid", {31'h0, ov0}, 32'h0);
    check("async_word_count0", {16'h0, wc0}, 32'h0);
    check("async_word_count1", {16'h0, wc1}, 32'h0);
    flush();
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    fd_base = nfd0;
    frame_seq(100);
    idle(3);
    check("rerun_word_count", {16'h0, wc0}, 32'd32);
    check("rerun_last_word", {16'h0, last0}, 32'h3F3E);
    check("rerun_frames", nfd0 - fd_base, 1);
    check("pending_words0", eq0.size(), 0);
    check("pending_words1", eq1.size(), 0);
    check("pending_sync0", sq0.size(), 0);
    check("pending_sync1", sq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
